mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Arbiter sharing one single-ported, variable-latency memory between the pipeline's instruction-fetch port and data (lw/sw) port.
- Sits between the core and the unified memory.
- Issues one memory transaction at a time and returns the result to the granted requester.
- Produces a combined stall for the pipeline.
- Data port has fixed priority; a starvation counter guarantees fetch progress.
- A timeout aborts accesses the memory never completes.

Parameters:
- DATA_W, 32: data and address width (from def.h).
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits; the next grant is forced to fetch.
- TIMEOUT, 64: BUSY cycles without mem_ready before the access is aborted with err.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  DATA_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_ack
- i_ack  out  1  one-cycle fetch completion
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  DATA_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid while d_ack
- d_ack  out  1  one-cycle data completion
- err  out  1  pulses with the ack when the access was aborted or misaligned
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  DATA_W  word address, bits [1:0] forced to 0
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completion, sampled only while mem_req is high
- stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; mem_req, mem_we, i_ack, d_ack, err = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; starve and timeout counters = 0.
- Reset mid-transaction drops mem_req immediately and loses the access; the requester re-presents it.
- States:
  - IDLE:
    - No request: stay.
    - Otherwise grant by priority: d_req wins unless starve == STARVE_MAX and i_req is high, then i_req wins.
    - Latch addr/we/wdata of the winner, set mem_req = 1, go to BUSY.
    - Misaligned addr (addr[1:0] != 0): issue nothing, go directly to DONE with err = 1.
  - BUSY:
    - mem_req, mem_we, mem_addr, mem_wdata held stable.
    - On mem_ready = 1: capture mem_rdata into the granted port's rdata (loads and fetches only), drop mem_req, go to DONE.
    - Timeout counter increments each BUSY cycle. On reaching TIMEOUT: drop mem_req, rdata = 0, err = 1, go to DONE.
  - DONE:
    - Assert the granted port's ack (and err if set) for exactly this cycle, then go to IDLE.
    - Requests are not sampled in DONE, so a requester seeing ack may keep req high for a new access without being double-granted.
- Latency: req sampled in IDLE at T -> mem_req high T+1 -> mem_ready at T+1 -> ack at T+2 -> IDLE at T+3. Minimum 3 cycles per access.
- Starve counter:
  - Increments when d is granted while i_req is high, saturating at STARVE_MAX.
  - Cleared when i is granted, or when i_req is low in IDLE.
- Store: d_rdata is left unchanged; d_ack only.
- A requester dropping req while granted is a protocol violation; the arbiter completes the access and still acks.
- i_ack and d_ack are never high in the same cycle.
- mem_we is never high unless mem_req is high.

Decomposition:
- def.h gains:
  - ARB_IDLE / ARB_BUSY / ARB_DONE state encodings (2 bits).
  - ARB_GNT_I / ARB_GNT_D grant codes.
  - Default STARVE_MAX and TIMEOUT values.
- One natural sub-module, arb_pick: the combinational priority/starvation picker. Inputs: i_req, d_req, starve_full. Output: grant code. Everything else stays in mem_arb.

Test Plan:
- Fetch only: i_req=1, i_addr=0x40, memory ready after 1 cycle with 0x2008000A -> i_ack at T+2, i_rdata=0x2008000A, stall high T..T+1, low at T+2.
- Simultaneous: i_req and d_req (load 0x100, data 0x5) at T -> d granted first with d_ack, d_rdata=0x5; then fetch granted with i_ack; mem_addr sequence 0x100 then the fetch address.
- Starvation (STARVE_MAX=4): d_req held continuously with back-to-back loads, i_req held -> after exactly 4 d_acks the 5th grant is i.
- Store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, 3-cycle memory latency -> mem_we/mem_addr/mem_wdata stable for all BUSY cycles, one d_ack, d_rdata unchanged.
- Timeout (TIMEOUT=8): mem_ready never asserted -> mem_req drops after 8 BUSY cycles; ack and err pulse together, rdata=0. Misaligned d_addr=0x102 -> err with no mem_req.
- Reset mid-BUSY: rst_n low asynchronously -> mem_req=0 in the same cycle, no ack issued; after release, the same request completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
package mem_arb_pkg;

    // Arbiter controller states.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_e;

    // Which requester owns the current access.
    typedef enum logic {
        ARB_GNT_I = 1'b0,
        ARB_GNT_D = 1'b1
    } arb_gnt_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

    // A word access must have its two low address bits clear.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant picker: data port has priority unless the fetch
// port has been passed over too many times in a row.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  logic     starve_full,
    output arb_gnt_e gnt
);

    // Data wins by default; a starved, waiting fetch overrides it.
    always_comb begin
        gnt = ARB_GNT_I;
        if (d_req && !(starve_full && i_req)) begin
            gnt = ARB_GNT_D;
        end else begin
            gnt = ARB_GNT_I;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// Shares one single-ported, variable-latency memory between the fetch
// and data ports, one transaction at a time, with a starvation guard
// for fetch and a timeout for accesses the memory never completes.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_FULL = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    arb_gnt_e          gnt_q, gnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic              err_q, err_d;

    arb_gnt_e          pick_s;
    logic              starve_full_s;
    logic [DATA_W-1:0] win_addr_s;
    logic              win_we_s;

    assign starve_full_s = (starve_q == STARVE_FULL);

    mem_arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .starve_full (starve_full_s),
        .gnt         (pick_s)
    );

    // Address and direction of whichever requester the picker chose.
    always_comb begin
        win_addr_s = i_addr;
        win_we_s   = 1'b0;
        if (pick_s == ARB_GNT_D) begin
            win_addr_s = d_addr;
            win_we_s   = d_we;
        end else begin
            win_addr_s = i_addr;
            win_we_s   = 1'b0;
        end
    end

    // Next-state, grant, counters and registered outputs.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (i_req || d_req) begin
                    gnt_d = pick_s;
                    tmo_d = '0;
                    // Starvation only accrues while a fetch is actually waiting.
                    if (pick_s == ARB_GNT_D && i_req) begin
                        starve_d = starve_full_s ? starve_q : starve_q + SW'(1);
                    end else begin
                        starve_d = '0;
                    end
                    if (is_misaligned(win_addr_s[1:0])) begin
                        // Never reaches the memory; report straight away.
                        state_d = ARB_DONE;
                        err_d   = 1'b1;
                        i_ack_d = (pick_s == ARB_GNT_I);
                        d_ack_d = (pick_s == ARB_GNT_D);
                        if (pick_s == ARB_GNT_I) begin
                            i_rdata_d = '0;
                        end else if (!d_we) begin
                            d_rdata_d = '0;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        state_d     = ARB_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = win_we_s;
                        mem_addr_d  = {win_addr_s[DATA_W-1:2], 2'b00};
                        mem_wdata_d = (pick_s == ARB_GNT_D) ? d_wdata : '0;
                    end
                end else begin
                    starve_d = '0;
                end
            end

            ARB_BUSY: begin
                if (mem_ready || (tmo_q == TMO_LAST)) begin
                    state_d   = ARB_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    tmo_d     = '0;
                    err_d     = !mem_ready;
                    i_ack_d   = (gnt_q == ARB_GNT_I);
                    d_ack_d   = (gnt_q == ARB_GNT_D);
                    // Stores leave read data alone; aborted reads return zero.
                    if (gnt_q == ARB_GNT_I) begin
                        i_rdata_d = mem_ready ? mem_rdata : '0;
                    end else if (!mem_we_q) begin
                        d_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            ARB_DONE: begin
                // Requests are deliberately ignored here so a held req
                // is not granted twice.
                state_d = ARB_IDLE;
            end

            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            gnt_q       <= ARB_GNT_I;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign err       = err_q;
    assign stall     = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb with a small latency-programmable memory.
module tb_mem_arb;

    localparam int W = 32;

    logic         clk, rst_n;
    logic         i_req, d_req, d_we;
    logic [W-1:0] i_addr, d_addr, d_wdata;
    logic [W-1:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic         i_ack, d_ack, err, mem_req, mem_we, mem_ready, stall;

    typedef struct packed {
        logic         port_d;
        logic [W-1:0] rdata;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic         ack_log[$];
    logic [W-1:0] addr_log[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           mem_lat = 1;
    int           busy_cnt = 0;
    logic         prev_req = 1'b0;
    logic [W-1:0] last_d = '0;

    mem_arb #(.DATA_W(W), .STARVE_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        case (a)
            32'h0000_0040: return 32'h2008_000A;
            32'h0000_0100: return 32'h0000_0005;
            default:       return {a[15:0], 16'h5A5A};
        endcase
    endfunction

    // Memory: raises mem_ready in the mem_lat-th request cycle (0 = never).
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                busy_cnt = busy_cnt + 1;
                if (mem_lat != 0 && busy_cnt == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = mem_we ? 32'hBAD0_BAD0 : mem_word(mem_addr);
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                end
            end else begin
                busy_cnt  = 0;
                mem_ready = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Scoreboard: every ack pops one expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                vectors = vectors + 1;
                if (sb.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL sb_unexpected_ack: i_ack=%b d_ack=%b, required no ack", i_ack, d_ack);
                end else begin
                    e = sb.pop_front();
                    if ((e.port_d ? {i_ack, d_ack} : {d_ack, i_ack}) !== 2'b01 ||
                        err !== e.err ||
                        (e.port_d ? d_rdata : i_rdata) !== e.rdata) begin
                        miscompares = miscompares + 1;
                        $display("FAIL sb_ack: i_ack=%b d_ack=%b err=%b rdata=%h, required port_d=%b err=%b rdata=%h",
                                 i_ack, d_ack, err, e.port_d ? d_rdata : i_rdata, e.port_d, e.err, e.rdata);
                    end
                end
            end
            if (err && !(i_ack || d_ack)) begin
                vectors = vectors + 1;
                miscompares = miscompares + 1;
                $display("FAIL err_without_ack: err=1, required 0");
            end
            if (mem_we && !mem_req) begin
                vectors = vectors + 1;
                miscompares = miscompares + 1;
                $display("FAIL we_without_req: mem_we=1 mem_req=0, required mem_we=0");
            end
        end
    end

    // Runs the bus until n acks are seen; drops each req on its ack unless kept.
    task automatic service(input int budget, input int n_acks, input bit keep_d,
                           output int got, output int busy, output bit unstable);
        logic [W-1:0] s_addr, s_wdata;
        logic         s_we;
        got = 0; busy = 0; unstable = 1'b0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0;
        for (int c = 0; c < budget && got < n_acks; c++) begin
            @(negedge clk);
            if (mem_req) begin
                busy = busy + 1;
                if (!prev_req) begin
                    addr_log.push_back(mem_addr);
                    s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
                end else if (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_we !== s_we) begin
                    unstable = 1'b1;
                end
            end
            prev_req = mem_req;
            if (i_ack) begin
                i_req = 1'b0;
                ack_log.push_back(1'b0);
                got = got + 1;
            end
            if (d_ack) begin
                if (!keep_d) d_req = 1'b0;
                ack_log.push_back(1'b1);
                got = got + 1;
            end
        end
        vectors = vectors + 1;
        if (got != n_acks) begin
            miscompares = miscompares + 1;
            $display("FAIL ack_budget: got %0d acks, required %0d", got, n_acks);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        vectors = vectors + 1;
        if ({mem_req, mem_we, i_ack, d_ack, err, stall} !== 6'b000000 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            miscompares = miscompares + 1;
            $display("FAIL reset_state: req/we/iack/dack/err/stall=%b addr=%h wdata=%h irdata=%h drdata=%h, required all 0",
                     {mem_req, mem_we, i_ack, d_ack, err, stall}, mem_addr, mem_wdata, i_rdata, d_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        mem_lat = 1;
        i_req = 1'b1; i_addr = 32'h40;
        sb.push_back('{port_d: 1'b0, rdata: 32'h2008_000A, err: 1'b0});
        #1;
        vectors = vectors + 1;
        if (stall !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL fetch_stall_T: stall=%b, required 1", stall);
        end
        @(negedge clk);
        vectors = vectors + 1;
        if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || stall !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL fetch_busy: mem_req=%b addr=%h we=%b stall=%b, required 1/00000040/0/1",
                     mem_req, mem_addr, mem_we, stall);
        end
        @(negedge clk);
        vectors = vectors + 1;
        if (i_ack !== 1'b1 || stall !== 1'b0 || i_rdata !== 32'h2008_000A) begin
            miscompares = miscompares + 1;
            $display("FAIL fetch_ack_T2: i_ack=%b stall=%b i_rdata=%h, required 1/0/2008000a", i_ack, stall, i_rdata);
        end
        i_req = 1'b0;
        @(negedge clk);
        vectors = vectors + 1;
        if (i_ack !== 1'b0 || mem_req !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL fetch_ack_pulse: i_ack=%b mem_req=%b, required 0/0", i_ack, mem_req);
        end
        prev_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        int got, busy;
        bit unst;
        mem_lat = 1;
        addr_log.delete();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        sb.push_back('{port_d: 1'b1, rdata: 32'h5, err: 1'b0});
        sb.push_back('{port_d: 1'b0, rdata: 32'h2008_000A, err: 1'b0});
        last_d = 32'h5;
        service(40, 2, 1'b0, got, busy, unst);
        vectors = vectors + 1;
        if (addr_log.size() != 2 || addr_log[0] !== 32'h100 || addr_log[1] !== 32'h40) begin
            miscompares = miscompares + 1;
            $display("FAIL simul_addr_seq: %0d addrs first=%h, required 2 addrs 00000100 then 00000040",
                     addr_log.size(), addr_log.size() > 0 ? addr_log[0] : 32'h0);
        end
    endtask

    task automatic test_starvation();
        int got, busy;
        bit unst;
        logic [4:0] order;
        mem_lat = 1;
        ack_log.delete();
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        for (int k = 0; k < 4; k++) sb.push_back('{port_d: 1'b1, rdata: 32'h5, err: 1'b0});
        sb.push_back('{port_d: 1'b0, rdata: 32'h2008_000A, err: 1'b0});
        service(80, 5, 1'b1, got, busy, unst);
        d_req = 1'b0;
        order = '0;
        for (int k = 0; k < 5 && k < ack_log.size(); k++) order[4-k] = ack_log[k];
        vectors = vectors + 1;
        if (ack_log.size() != 5 || order !== 5'b11110) begin
            miscompares = miscompares + 1;
            $display("FAIL starve_order: %0d acks order=%b (1=d), required 5 acks 11110", ack_log.size(), order);
        end
        repeat (3) @(negedge clk);
        prev_req = 1'b0;
    endtask

    task automatic test_store();
        int got, busy;
        bit unst;
        mem_lat = 3;
        addr_log.delete();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        sb.push_back('{port_d: 1'b1, rdata: last_d, err: 1'b0});
        service(30, 1, 1'b0, got, busy, unst);
        vectors = vectors + 1;
        if (busy != 3 || unst || addr_log.size() != 1) begin
            miscompares = miscompares + 1;
            $display("FAIL store_busy: busy=%0d unstable=%b issues=%0d, required 3/0/1", busy, unst, addr_log.size());
        end
        vectors = vectors + 1;
        if (addr_log.size() == 1 && addr_log[0] !== 32'h20) begin
            miscompares = miscompares + 1;
            $display("FAIL store_addr: mem_addr=%h, required 00000020", addr_log[0]);
        end
        d_we = 1'b0;
    endtask

    task automatic test_timeout();
        int got, busy;
        bit unst;
        mem_lat = 0;
        addr_log.delete();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        sb.push_back('{port_d: 1'b1, rdata: 32'h0, err: 1'b1});
        last_d = 32'h0;
        service(40, 1, 1'b0, got, busy, unst);
        vectors = vectors + 1;
        if (busy != 8) begin
            miscompares = miscompares + 1;
            $display("FAIL timeout_cycles: busy=%0d, required 8", busy);
        end
        mem_lat = 1;
        addr_log.delete();
        d_req = 1'b1; d_addr = 32'h102;
        sb.push_back('{port_d: 1'b1, rdata: 32'h0, err: 1'b1});
        service(20, 1, 1'b0, got, busy, unst);
        vectors = vectors + 1;
        if (busy != 0 || addr_log.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL misaligned_no_req: busy=%0d, required 0", busy);
        end
    endtask

    task automatic test_reset_mid_busy();
        int got, busy;
        bit unst;
        mem_lat = 0;
        i_req = 1'b1; i_addr = 32'h40;
        for (int c = 0; c < 10 && !mem_req; c++) @(negedge clk);
        @(negedge clk);
        vectors = vectors + 1;
        if (mem_req !== 1'b1) begin
            miscompares = miscompares + 1;
            $display("FAIL rst_mid_reach: mem_req=%b, required 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors = vectors + 1;
        if (mem_req !== 1'b0) begin
            miscompares = miscompares + 1;
            $display("FAIL rst_mid_drop: mem_req=%b, required 0", mem_req);
        end
        @(negedge clk);
        vectors = vectors + 1;
        if (i_ack !== 1'b0 || mem_req !== 1'b0 || i_rdata !== 32'h0) begin
            miscompares = miscompares + 1;
            $display("FAIL rst_mid_hold: i_ack=%b mem_req=%b i_rdata=%h, required 0/0/0", i_ack, mem_req, i_rdata);
        end
        rst_n = 1'b1;
        mem_lat = 1;
        last_d = 32'h0;
        prev_req = 1'b0;
        sb.push_back('{port_d: 1'b0, rdata: 32'h2008_000A, err: 1'b0});
        service(20, 1, 1'b0, got, busy, unst);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_timeout();
        test_reset_mid_busy();
        repeat (4) @(negedge clk);
        vectors = vectors + 1;
        if (sb.size() != 0) begin
            miscompares = miscompares + 1;
            $display("FAIL sb_drain: %0d expected acks outstanding, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
